act_share_arbiter: RTL and testbench

- Shares one pipelined PWL activation unit (Q8.8 in/out, fixed latency, no stall input) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready on the request side and a per-requester single-entry response slot with valid/ready.
- Each result is tagged with its requester ID, carried alongside the unit's pipeline, and steered back to the requester that issued it.
- Sits between the GAN layer engines and the shared tanh/activation datapath.

---
 rtl/act_share_arbiter_pkg.sv | 36 +++
 rtl/act_share_arbiter_rr_pick.sv | 47 ++++
 rtl/act_share_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_act_share_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_share_arbiter_pkg.sv
// Shared definitions for the activation-unit sharing logic.
//
// Contents:
//   DATA_W       default sample width (Q8.8 signed)
//   ONE/NEG_ONE  Q8.8 encodings of +1.0 and -1.0 (the saturation levels of tanh)
//   MAX_ID_W     tag id width large enough for the largest supported requester count
//   tag_t        tag carried alongside the activation pipeline {valid, id}
//   clog2()      ceiling log2, usable in constant expressions
package act_share_arbiter_pkg;

    localparam int DATA_W   = 16;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    localparam logic signed [DATA_W-1:0] ONE     = 16'sd256;
    localparam logic signed [DATA_W-1:0] NEG_ONE = -16'sd256;

    // The id field is sized for MAX_REQ so the struct is the same for every
    // instance; narrower configurations simply leave the upper id bits zero.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) begin
                result = b + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/act_share_arbiter_rr_pick.sv
// Round-robin picker: purely combinational, reusable by any shared-resource
// arbiter.
//
// Ports:
//   eligible     in   N      per-requester eligibility
//   ptr          in   IDX_W  highest-priority index for this cycle (must be < N)
//   grant        out  N      one-hot grant (all zero when nothing is eligible)
//   grant_idx    out  IDX_W  index of the granted requester (0 when no grant)
//   grant_valid  out  1      a grant was made
//
// The search visits ptr, ptr+1, ... modulo N and stops at the first eligible
// requester. The double loop avoids variable bit-selects so that N need not be
// a power of two.
module act_share_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    int idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            for (int j = 0; j < N; j++) begin
                if (!grant_valid && (j == idx) && eligible[j]) begin
                    grant_valid = 1'b1;
                    grant[j]    = 1'b1;
                    grant_idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/act_share_arbiter.sv
// Shares one pipelined PWL activation unit (fixed latency, no stall) between
// NUM_REQ requesters. Requests are granted round-robin, each issued op is
// tagged with its requester id in a tag pipe that runs alongside the unit, and
// the result is steered into that requester's single-entry response slot.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both 1. valid, once raised, is expected to hold its
// payload until the transfer; ready may depend combinationally on valid.
// On the request side req_ready is the combinational one-hot grant. On the
// response side resp_valid is the registered "slot full" flag.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              grant enable; 0 blocks new grants, in-flight ops finish
//   req_valid/x     per-requester request valid and operand (slice i = req i)
//   req_ready       one-hot grant, combinational
//   resp_valid/y    per-requester response slot full flag and contents
//   resp_ready      requester accepts its response
//   act_valid_in/x  issue port to the activation unit
//   act_valid_out/y result port from the activation unit
//   idle            nothing in flight, tag pipe empty, all slots empty
//   proto_err       sticky: unit output valid disagreed with the tag pipe
//   op_cnt          number of issued ops, 16-bit wrapping
module act_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = act_share_arbiter_pkg::DATA_W,
    parameter int ACT_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_x,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [NUM_REQ*DATA_W-1:0]   resp_y,
    input  logic [NUM_REQ-1:0]          resp_ready,
    output logic                        act_valid_in,
    output logic [DATA_W-1:0]           act_x,
    input  logic                        act_valid_out,
    input  logic [DATA_W-1:0]           act_y,
    output logic                        idle,
    output logic                        proto_err,
    output logic [15:0]                 op_cnt
);

    import act_share_arbiter_pkg::*;

    localparam int ID_W = clog2(NUM_REQ);

    // State
    logic [NUM_REQ-1:0]        inflight;
    logic [NUM_REQ-1:0]        full;
    logic [NUM_REQ*DATA_W-1:0] slot;
    tag_t                      tag_pipe [ACT_LAT];
    logic [ID_W-1:0]           ptr;
    logic [DATA_W-1:0]         last_x;
    logic                      proto_err_q;
    logic [15:0]               op_cnt_q;

    // Arbitration
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;
    logic [ID_W-1:0]    next_ptr;
    logic [DATA_W-1:0]  sel_x;

    // Completion
    tag_t               tail;
    logic [NUM_REQ-1:0] retire_vec;
    logic [NUM_REQ-1:0] land_vec;
    logic [NUM_REQ-1:0] drain_vec;
    logic               proto_mismatch;
    logic               pipe_busy;

    // A requester may have one op outstanding. A full slot only blocks a new
    // issue if it is not being drained this same cycle.
    assign eligible = req_valid & {NUM_REQ{en}} & ~inflight & (~full | resp_ready);

    act_share_arbiter_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_pick (
        .eligible    (eligible),
        .ptr         (ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + ID_W'(1);
        end
    end

    // With no grant the issue data holds the last issued operand.
    always_comb begin
        sel_x = last_x;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_x = req_x[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready    = grant;
    assign act_valid_in = grant_valid;
    assign act_x        = sel_x;

    // The tail of the tag pipe lines up with the unit's output cycle.
    assign tail           = tag_pipe[ACT_LAT-1];
    assign proto_mismatch = act_valid_out ^ tail.valid;
    assign drain_vec      = full & resp_ready;

    // A valid tail always retires its op so nothing can hang; the result is
    // only written if the unit actually produced one in that cycle.
    always_comb begin
        retire_vec = '0;
        land_vec   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tail.valid && (tail.id == MAX_ID_W'(i))) begin
                retire_vec[i] = 1'b1;
                land_vec[i]   = act_valid_out;
            end
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int s = 0; s < ACT_LAT; s++) begin
            pipe_busy = pipe_busy | tag_pipe[s].valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= '0;
            full        <= '0;
            slot        <= '0;
            ptr         <= '0;
            last_x      <= '0;
            proto_err_q <= 1'b0;
            op_cnt_q    <= '0;
            for (int s = 0; s < ACT_LAT; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    inflight[i] <= 1'b1;
                end else if (retire_vec[i]) begin
                    inflight[i] <= 1'b0;
                end
                // A landing result wins over a drain in the same cycle.
                if (land_vec[i]) begin
                    full[i]                     <= 1'b1;
                    slot[i*DATA_W +: DATA_W]    <= act_y;
                end else if (drain_vec[i]) begin
                    full[i] <= 1'b0;
                end
            end

            tag_pipe[0].valid <= grant_valid;
            tag_pipe[0].id    <= MAX_ID_W'(grant_idx);
            for (int s = 1; s < ACT_LAT; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end

            if (grant_valid) begin
                ptr      <= next_ptr;
                last_x   <= sel_x;
                op_cnt_q <= op_cnt_q + 16'd1;
            end

            if (proto_mismatch) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign resp_valid = full;
    assign resp_y     = slot;
    assign proto_err  = proto_err_q;
    assign op_cnt     = op_cnt_q;
    assign idle       = ~(|inflight) & ~(|full) & ~pipe_busy;

endmodule

// File: tb/tb_act_share_arbiter.sv
// Directed bench for act_share_arbiter (NUM_REQ=4, DATA_W=16, ACT_LAT=1).
// A one-cycle PWL tanh stand-in drives the activation result port:
//   x >= 2.0 -> +1.0, x <= -2.0 -> -1.0, otherwise y = (x*175) >>> 8.
// Hand values: 0x0100->0x00AF, 0x0080->0x0057, 0xFF00->0xFF51,
//              0x0400/0x0200->0x0100, 0xFC00->0xFF00.
module tb_act_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [63:0] req_x;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [63:0] resp_y;
    logic [3:0]  resp_ready;
    logic        act_valid_in;
    logic [15:0] act_x;
    logic        act_valid_out;
    logic [15:0] act_y;
    logic        idle;
    logic        proto_err;
    logic [15:0] op_cnt;

    logic        model_v;
    logic [15:0] model_y;
    logic        inject;

    int          errors;
    int          checks;
    logic [15:0] exp_q[$];
    logic        reached;

    act_share_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (16),
        .ACT_LAT (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req_valid     (req_valid),
        .req_x         (req_x),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_y        (resp_y),
        .resp_ready    (resp_ready),
        .act_valid_in  (act_valid_in),
        .act_x         (act_x),
        .act_valid_out (act_valid_out),
        .act_y         (act_y),
        .idle          (idle),
        .proto_err     (proto_err),
        .op_cnt        (op_cnt)
    );

    // Clock / reset-safe activation stand-in
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pwl(input logic [15:0] x);
        logic signed [15:0] sx;
        logic signed [31:0] p;
        sx = x;
        if (sx >= 16'sd512) return 16'h0100;
        if (sx <= -16'sd512) return 16'hFF00;
        p = sx * 32'sd175;
        return 16'(p >>> 8);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_v <= 1'b0;
            model_y <= '0;
        end else begin
            model_v <= act_valid_in;
            model_y <= pwl(act_x);
        end
    end

    assign act_valid_out = model_v | inject;
    assign act_y         = model_y;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver / checker tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int i, input logic [15:0] v);
        req_x[i*16 +: 16] = v;
    endtask

    function automatic logic [15:0] slot(input int i);
        return resp_y[i*16 +: 16];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reached    = 1'b0;
        rst_n      = 1'b0;
        en         = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        resp_ready = '0;
        inject     = 1'b0;

        // Reset state
        #3;
        chk("rst_req_ready", req_ready, 4'h0);
        chk("rst_resp_valid", resp_valid, 4'h0);
        chk("rst_resp_y", resp_y, 64'h0);
        chk("rst_op_cnt", op_cnt, 16'h0);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_act_valid_in", act_valid_in, 1'b0);
        #9 rst_n = 1'b1;

        // All four requesters, x=1.0, slots held full
        step();
        en = 1'b1; req_valid = 4'hF; resp_ready = 4'h0;
        for (int i = 0; i < 4; i++) set_x(i, 16'h0100);
        #2;
        chk("t1_grant0", req_ready, 4'b0001);
        chk("t1_act_valid_in", act_valid_in, 1'b1);
        chk("t1_act_x", act_x, 16'h0100);
        step(); #2;
        chk("t1_grant1", req_ready, 4'b0010);
        step(); #2;
        chk("t1_grant2", req_ready, 4'b0100);
        chk("t1_resp0_valid", resp_valid, 4'b0001);
        chk("t1_resp0_y", slot(0), 16'h00AF);
        step(); #2;
        chk("t1_grant3", req_ready, 4'b1000);
        step(); req_valid = 4'h0; #2;
        chk("t1_no_grant", req_ready, 4'h0);
        chk("t1_op_cnt", op_cnt, 16'd4);
        chk("t1_act_x_hold", act_x, 16'h0100);
        step(); #2;
        chk("t1_all_valid", resp_valid, 4'hF);
        chk("t1_all_y", resp_y, {4{16'h00AF}});
        step(); resp_ready = 4'hF;
        step(); resp_ready = 4'h0; #2;
        chk("t1_drained", resp_valid, 4'h0);
        chk("t1_idle", idle, 1'b1);

        // Requester 2 alone, back-to-back operands
        step();
        req_valid = 4'b0100; set_x(2, 16'h0400); resp_ready = 4'hF; #2;
        chk("t2_grant_a", req_ready, 4'b0100);
        chk("t2_act_x_a", act_x, 16'h0400);
        step(); set_x(2, 16'hFC00); #2;
        chk("t2_credit_block", req_ready, 4'b0000);
        step(); #2;
        chk("t2_grant_b", req_ready, 4'b0100);
        chk("t2_resp_a_valid", resp_valid, 4'b0100);
        chk("t2_resp_a_y", slot(2), 16'h0100);
        chk("t2_act_x_b", act_x, 16'hFC00);
        step(); req_valid = 4'h0; #2;
        chk("t2_between", resp_valid, 4'b0000);
        step(); #2;
        chk("t2_resp_b_valid", resp_valid, 4'b0100);
        chk("t2_resp_b_y", slot(2), 16'hFF00);
        step(); resp_ready = 4'h0; #2;
        chk("t2_idle", idle, 1'b1);

        // Requester 1 blocked by its own full slot while 0 and 3 proceed
        step();
        req_valid = 4'b0010; set_x(1, 16'h0080); #2;
        chk("t3_fill_grant", req_ready, 4'b0010);
        step(); #2;
        chk("t3_inflight", req_ready, 4'b0000);
        step();
        req_valid = 4'b1011; resp_ready = 4'b1001;
        set_x(0, 16'h0100); set_x(3, 16'h0100); #2;
        chk("t3_g3_a", req_ready, 4'b1000);
        chk("t3_slot1_full", resp_valid, 4'b0010);
        chk("t3_slot1_y", slot(1), 16'h0057);
        step(); #2;
        chk("t3_g0_a", req_ready, 4'b0001);
        step(); #2;
        chk("t3_g3_b", req_ready, 4'b1000);
        step(); #2;
        chk("t3_g0_b", req_ready, 4'b0001);
        step(); resp_ready = 4'b1011; #2;
        chk("t3_release", req_ready, 4'b0010);
        step(); req_valid = 4'h0; resp_ready = 4'hF;
        step();
        step(); #2;
        chk("t3_idle", idle, 1'b1);
        resp_ready = 4'h0;

        // en dropped during a burst (ptr is 2 here)
        step();
        req_valid = 4'hF; resp_ready = 4'hF;
        set_x(0, 16'h0100); set_x(1, 16'h0100); set_x(2, 16'h0200); set_x(3, 16'hFF00);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'hFF51);
        #2;
        chk("t4_g2", req_ready, 4'b0100);
        step(); #2;
        chk("t4_g3", req_ready, 4'b1000);
        step(); en = 1'b0; #2;
        chk("t4_blocked", req_ready, 4'b0000);
        chk("t4_resp2_valid", resp_valid, 4'b0100);
        chk("t4_resp2_y", slot(2), exp_q.pop_front());
        step(); #2;
        chk("t4_blocked2", req_ready, 4'b0000);
        chk("t4_resp3_valid", resp_valid, 4'b1000);
        chk("t4_resp3_y", slot(3), exp_q.pop_front());
        step(); #2;
        chk("t4_idle", idle, 1'b1);
        step(); en = 1'b1; #2;
        chk("t4_ptr_kept", req_ready, 4'b0001);
        step(); req_valid = 4'h0;
        step();
        step(); #2;
        chk("t4_idle2", idle, 1'b1);
        chk("t4_op_cnt", op_cnt, 16'd15);
        resp_ready = 4'h0;

        // Unsolicited activation output
        step(); #2;
        chk("t5_pre", proto_err, 1'b0);
        inject = 1'b1;
        step(); inject = 1'b0; #2;
        chk("t5_proto_err", proto_err, 1'b1);
        chk("t5_no_resp", resp_valid, 4'h0);
        step(); step(); #2;
        chk("t5_sticky", proto_err, 1'b1);

        // Drive op_cnt to 0xFFFF, then one more op
        step();
        req_valid = 4'hF; resp_ready = 4'hF;
        for (int n = 0; n < 70000; n++) begin
            step();
            if (op_cnt == 16'hFFFF) begin
                req_valid = 4'h0;
                reached   = 1'b1;
                break;
            end
        end
        chk("t6_reach_ffff", reached, 1'b1);
        step(); step(); step(); #2;
        chk("t6_idle", idle, 1'b1);
        req_valid = 4'b0001; #1;
        chk("t6_last_grant", req_ready, 4'b0001);
        step(); req_valid = 4'h0; #2;
        chk("t6_wrap", op_cnt, 16'h0000);
        step(); step();

        // Reset mid-burst
        req_valid = 4'hF; resp_ready = 4'h0;
        for (int i = 0; i < 4; i++) set_x(i, 16'h0100);
        step(); step(); #2;
        chk("t7_busy", idle, 1'b0);
        rst_n = 1'b0; req_valid = 4'h0; en = 1'b0; #1;
        chk("t7_resp_valid", resp_valid, 4'h0);
        chk("t7_resp_y", resp_y, 64'h0);
        chk("t7_op_cnt", op_cnt, 16'h0);
        chk("t7_proto_err", proto_err, 1'b0);
        chk("t7_idle", idle, 1'b1);
        chk("t7_req_ready", req_ready, 4'h0);
        chk("t7_act_x", act_x, 16'h0);
        #1 rst_n = 1'b1;
        step();
        en = 1'b1; req_valid = 4'b0100; set_x(2, 16'h0080); #2;
        chk("t7_post_grant", req_ready, 4'b0100);
        step(); req_valid = 4'h0;
        step(); #2;
        chk("t7_post_valid", resp_valid, 4'b0100);
        chk("t7_post_y", slot(2), 16'h0057);
        chk("t7_post_proto", proto_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
